// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg: mode encoding, default 800x600 timing and the colour-bar table.
package vga_timing_pkg;
  typedef enum logic [1:0] {
    MODE_EXT   = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_CHECK = 2'd3
  } mode_t;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;
  // {r,g,b} enables per bar index, left to right:
  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: video timing bus.
//   master = generator side: takes en/mode/pix_*, drives req_*/pix_req/r/g/b/hsync/vsync/de/frame
//   slave  = consumer side (framebuffer reader / DAC)
interface vga_timing_gen_if #(
  parameter int CNT_W   = 12,
  parameter int COLOR_W = 5,
  parameter int FRAME_W = 16
);
  logic               en;
  logic [1:0]         mode;
  logic [CNT_W-1:0]   req_x;
  logic [CNT_W-1:0]   req_y;
  logic               pix_req;
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic [FRAME_W-1:0] frame;
  modport master (
    input  en, mode, pix_r, pix_g, pix_b,
    output req_x, req_y, pix_req, r, g, b, hsync, vsync, de, frame
  );
  modport slave (
    output en, mode, pix_r, pix_g, pix_b,
    input  req_x, req_y, pix_req, r, g, b, hsync, vsync, de, frame
  );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// vga_axis_counter: one video axis (h or v) counting 0..TOTAL-1.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous return to 0 (generator disabled)
//   advance    : step the count this cycle
//   count      : current position
//   wrap       : count is at TOTAL-1 and advancing this cycle
//   active     : count is inside the visible region
//   sync       : sync level for this position, POL applied
module vga_axis_counter #(
  parameter int ACTIVE = 800,
  parameter int FP     = 40,
  parameter int SYNC   = 128,
  parameter int BP     = 88,
  parameter bit POL    = 1'b0,
  parameter int CNT_W  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             active,
  output logic             sync
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACTIVE + FP + SYNC + BP - 1);
  localparam logic [CNT_W-1:0] ACT  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] S_LO = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] S_HI = CNT_W'(ACTIVE + FP + SYNC);
  assign wrap   = advance && count == LAST;
  assign active = count < ACT;
  assign sync   = (count >= S_LO && count < S_HI) ? POL : ~POL;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (advance) count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised video timing generator with test-pattern source.
//   clk, rst_n : pixel clock, async active-low reset
//   bus.en     : run enable; low holds counters at (0,0) with blank outputs
//   bus.mode   : 0 external, 1 gradient, 2 colour bars, 3 checkerboard (latched at frame start)
//   bus.req_x/req_y/pix_req : current counter position, pixel wanted next edge
//   bus.pix_r/g/b           : external pixel, sampled at the edge ending the pix_req cycle
//   bus.r/g/b/hsync/vsync/de/frame : registered video outputs, one cycle behind the counters
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 12,
  parameter int COLOR_W  = 5,
  parameter int FRAME_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  vga_timing_gen_if.master  bus
);
  logic [CNT_W-1:0]   h, v;
  logic               h_wrap, v_wrap, h_act, v_act, h_sync, v_sync, act, tile;
  logic [2:0]         bar, bar_rgb;
  logic [COLOR_W-1:0] mask, cr, cg, cb;
  mode_t              mode_q;
  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CNT_W(CNT_W)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .clr(~bus.en), .advance(bus.en),
    .count(h), .wrap(h_wrap), .active(h_act), .sync(h_sync)
  );
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CNT_W(CNT_W)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .clr(~bus.en), .advance(h_wrap),
    .count(v), .wrap(v_wrap), .active(v_act), .sync(v_sync)
  );
  assign act         = bus.en && h_act && v_act;
  assign bus.req_x   = h;
  assign bus.req_y   = v;
  assign bus.pix_req = act;
  // Bar boundaries are elaboration constants; the last one crossed is the bar index.
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) bar = h >= CNT_W'(k * H_ACTIVE / 8) ? 3'(k) : bar;
  end
  always_comb begin
    mask    = bus.frame[COLOR_W-1:0];
    tile    = h[4] ^ v[4];
    bar_rgb = BAR_RGB[bar];
    cr = mode_q == MODE_EXT  ? bus.pix_r :
         mode_q == MODE_GRAD ? ~h[COLOR_W-1:0] ^ mask :
         mode_q == MODE_BARS ? {COLOR_W{bar_rgb[2]}} : {COLOR_W{tile}};
    cg = mode_q == MODE_EXT  ? bus.pix_g :
         mode_q == MODE_GRAD ? v[COLOR_W-1:0] ^ mask :
         mode_q == MODE_BARS ? {COLOR_W{bar_rgb[1]}} : {COLOR_W{tile}};
    cb = mode_q == MODE_EXT  ? bus.pix_b :
         mode_q == MODE_GRAD ? '0 :
         mode_q == MODE_BARS ? {COLOR_W{bar_rgb[0]}} : {COLOR_W{tile}};
  end
  // v_wrap implies h_wrap: this is the edge the counters return to (0,0).
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.r     <= '0;
      bus.g     <= '0;
      bus.b     <= '0;
      bus.de    <= 1'b0;
      bus.hsync <= ~HS_POL;
      bus.vsync <= ~VS_POL;
      bus.frame <= '0;
      mode_q    <= MODE_EXT;
    end else begin
      bus.r     <= act ? cr : '0;
      bus.g     <= act ? cg : '0;
      bus.b     <= act ? cb : '0;
      bus.de    <= act;
      bus.hsync <= bus.en ? h_sync : ~HS_POL;
      bus.vsync <= bus.en ? v_sync : ~VS_POL;
      if (v_wrap) bus.frame <= bus.frame + 1'b1;
      if (!bus.en || v_wrap) mode_q <= mode_t'(bus.mode);
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: small-timing bench with a position-based reference model.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int passed = 0;
  int total = 0;
  int n = 0;
  logic [15:0] fb = '0;
  logic [1:0] mq = '0;
  typedef struct { logic de; logic hs; logic [4:0] r; } vec_t;
  vec_t tbl [HT];
  logic [2:0] bar_col [8];
  vga_timing_gen_if #(.CNT_W(12), .COLOR_W(5), .FRAME_W(16)) vif ();
  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12), .COLOR_W(5), .FRAME_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(vif.master)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  function automatic logic [14:0] colour(input logic [1:0] m, input int x, input int y,
                                         input logic [15:0] f, input logic [4:0] pr,
                                         input logic [4:0] pg, input logic [4:0] pb);
    logic [4:0] xs, ys;
    logic [2:0] c;
    xs = 5'(x);
    ys = 5'(y);
    c = bar_col[x * 8 / HA];
    case (m)
      2'd0: return {pr, pg, pb};
      2'd1: return {~xs ^ f[4:0], ys ^ f[4:0], 5'd0};
      2'd2: return {{5{c[2]}}, {5{c[1]}}, {5{c[0]}}};
      default: return (((x >> 4) ^ (y >> 4)) & 1) != 0 ? 15'h7fff : 15'h0;
    endcase
  endfunction
  task automatic step(input logic e, input logic [1:0] m, input bit ramp);
    int h, v;
    bit act, ehs, evs;
    logic [14:0] c;
    h = n % HT;
    v = n / HT;
    vif.en = e;
    vif.mode = m;
    vif.pix_r = ramp ? 5'(h + 1) : 5'($urandom);
    vif.pix_g = 5'($urandom);
    vif.pix_b = 5'($urandom);
    #1;
    act = e && h < HA && v < VA;
    chk("req_x", vif.req_x, h);
    chk("req_y", vif.req_y, v);
    chk("pix_req", vif.pix_req, act);
    c = act ? colour(mq, h, v, fb, vif.pix_r, vif.pix_g, vif.pix_b) : 15'h0;
    ehs = !(e && h >= HA + HF && h < HA + HF + HS);
    evs = !(e && v >= VA + VF && v < VA + VF + VS);
    if (!e) begin n = 0; mq = m; end
    else if (n == FT - 1) begin n = 0; fb++; mq = m; end
    else n++;
    @(negedge clk);
    chk("de", vif.de, act);
    chk("r", vif.r, c[14:10]);
    chk("g", vif.g, c[9:5]);
    chk("b", vif.b, c[4:0]);
    chk("hsync", vif.hsync, ehs);
    chk("vsync", vif.vsync, evs);
    chk("frame", vif.frame, fb);
  endtask
  task automatic run_until(input logic [1:0] m, input int target);
    int i = 0;
    do begin step(1'b1, m, 1'b0); i++; end while (n != target && i < 2 * FT);
    chk("run_until_pos", n, target);
  endtask
  initial begin
    int vcnt, pf;
    bit spot, spot_seen;
    bar_col = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    tbl = '{'{1, 1, 1}, '{1, 1, 2}, '{1, 1, 3}, '{1, 1, 4}, '{1, 1, 5}, '{1, 1, 6}, '{1, 1, 7},
            '{1, 1, 8}, '{0, 1, 0}, '{0, 1, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 1, 0}, '{0, 1, 0}};
    vif.en = 1'b0;
    vif.mode = 2'd0;
    vif.pix_r = '0;
    vif.pix_g = '0;
    vif.pix_b = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_de", vif.de, 0);
    chk("rst_rgb", {vif.r, vif.g, vif.b}, 0);
    chk("rst_hsync", vif.hsync, 1);
    chk("rst_vsync", vif.vsync, 1);
    chk("rst_frame", vif.frame, 0);
    chk("rst_req_x", vif.req_x, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < HT; k++) begin
      step(1'b1, 2'd0, 1'b1);
      chk("tbl_de", vif.de, tbl[k].de);
      chk("tbl_hsync", vif.hsync, tbl[k].hs);
      chk("tbl_r", vif.r, tbl[k].r);
    end
    vcnt = 0;
    spot_seen = 0;
    for (int i = 0; i < 4 * FT && !(fb == 3 && n == 0); i++) begin
      spot = fb == 2 && n == 3 * HT + 1;
      pf = int'(fb);
      step(1'b1, 2'd1, 1'b0);
      if (spot) begin
        chk("grad_r", vif.r, 28);
        chk("grad_g", vif.g, 1);
        spot_seen = 1;
      end
      if (pf == 1 && !vif.vsync) vcnt++;
    end
    chk("grad_spot_reached", spot_seen, 1);
    chk("frame_after_3", vif.frame, 3);
    chk("vsync_low_cycles", vcnt, 14);
    run_until(2'd0, 0);
    run_until(2'd0, HT + 3);
    run_until(2'd2, 0);
    step(1'b1, 2'd2, 1'b0);
    chk("bar0_rgb", {vif.r, vif.g, vif.b}, 15'h7fff);
    step(1'b1, 2'd2, 1'b0);
    chk("bar1_r", vif.r, 31);
    chk("bar1_b", vif.b, 0);
    step(1'b1, 2'd2, 1'b0);
    chk("bar2_r", vif.r, 0);
    chk("bar2_b", vif.b, 31);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 49) != 0, 2'($urandom), 1'b0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom), 1'b0);
    run_until(2'd0, 0);
    run_until(2'd0, 2 * HT + 5);
    chk("pre_rst_de", vif.de, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_de", vif.de, 0);
    chk("async_rgb", {vif.r, vif.g, vif.b}, 0);
    chk("async_hsync", vif.hsync, 1);
    chk("async_vsync", vif.vsync, 1);
    chk("async_frame", vif.frame, 0);
    chk("async_req_x", vif.req_x, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    fb = '0;
    mq = '0;
    chk("release_de", vif.de, 0);
    step(1'b1, 2'd0, 1'b0);
    chk("first_de_after_rst", vif.de, 1);
    for (int i = 0; i < 2 * HT; i++) step(1'b1, 2'd0, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
